sd_spi_master: RTL

- Byte-oriented SPI mode-0 initiator that the core's SD interface uses to talk to an SD card: either the physical card pins or the virtual SD responder, selected outside this block.
- Sits between the CPU port decoder (Z-controller style data/config ports) and the SD SCK/MOSI/MISO/CS lines.
- Shifts one byte per request, MSB first, at a programmable SCK rate, and returns the received byte with a one-cycle completion strobe.

---
 rtl/sd_spi_master_if.sv | 30 +++
 rtl/sd_spi_master.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/sd_spi_master_if.sv
// CPU-side and SPI-side signals of the SD SPI master, grouped into one bundle.
// master: the view used by sd_spi_master itself.
// slave:  the view used by whatever drives the CPU ports and the SD card lines.
interface sd_spi_master_if #(
    parameter int DIV_W = 8
);
    logic [DIV_W-1:0] div;
    logic             cfg_we;
    logic             cfg_cs_n;
    logic             tx_we;
    logic [7:0]       tx_data;
    logic             rd_strobe;
    logic [7:0]       rx_data;
    logic             busy;
    logic             done;
    logic             spi_sck;
    logic             spi_mosi;
    logic             spi_miso;
    logic             spi_cs_n;

    modport master (
        input  div, cfg_we, cfg_cs_n, tx_we, tx_data, rd_strobe, spi_miso,
        output rx_data, busy, done, spi_sck, spi_mosi, spi_cs_n
    );

    modport slave (
        output div, cfg_we, cfg_cs_n, tx_we, tx_data, rd_strobe, spi_miso,
        input  rx_data, busy, done, spi_sck, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/sd_spi_master.sv
// Byte-wide SPI mode-0 initiator for the SD card path.
// One tx_we shifts one byte MSB first; SCK half-period is div+1 clk_sys cycles.
// Optional read-ahead (rd_strobe in IDLE shifts 8'hFF) is enabled by the macro
// SD_SPI_AUTOREAD_EN; without it rd_strobe is ignored.
module sd_spi_master #(
    parameter int         DIV_W    = 8,
    parameter logic [7:0] RX_RESET = 8'hFF
) (
    input logic             clk_sys,
    input logic             reset_n,
    sd_spi_master_if.master bus
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH} state_t;

    state_t           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [7:0]       rx_q, rx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             cs_q, cs_d;

    logic             start;
    logic [7:0]       start_byte;

`ifdef SD_SPI_AUTOREAD_EN
    // Start request: tx_we, or a CPU read of the data port (read-ahead of 8'hFF); tx_we wins.
    always_comb begin
        start      = bus.tx_we | bus.rd_strobe;
        start_byte = bus.tx_we ? bus.tx_data : 8'hFF;
    end
`else
    logic rd_strobe_unused;
    assign rd_strobe_unused = bus.rd_strobe;

    // Start request: only tx_we launches a transfer.
    always_comb begin
        start      = bus.tx_we;
        start_byte = bus.tx_data;
    end
`endif

    // Next-state logic: divider, bit counter, shifter, SCK/MOSI generation, chip select.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rx_d    = rx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        sck_d   = sck_q;
        mosi_d  = mosi_q;
        cs_d    = bus.cfg_we ? bus.cfg_cs_n : cs_q;

        case (state_q)
            IDLE: begin
                mosi_d = 1'b1;
                if (start) begin
                    shift_d = start_byte;
                    mosi_d  = start_byte[7];
                    bit_d   = 3'd0;
                    cnt_d   = '0;
                    div_d   = bus.div;
                    busy_d  = 1'b1;
                    state_d = LOW;
                end
            end
            LOW: begin
                if (cnt_q == div_q) begin
                    // Rising SCK edge: sample MISO into the freed LSB.
                    sck_d   = 1'b1;
                    shift_d = {shift_q[6:0], bus.spi_miso};
                    cnt_d   = '0;
                    state_d = HIGH;
                end else begin
                    cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            HIGH: begin
                if (cnt_q == div_q) begin
                    sck_d = 1'b0;
                    cnt_d = '0;
                    if (bit_q == 3'd7) begin
                        rx_d    = shift_q;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        mosi_d  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // After the shift, the next outgoing bit sits in the MSB.
                        bit_d   = bit_q + 3'd1;
                        mosi_d  = shift_q[7];
                        state_d = LOW;
                    end
                end else begin
                    cnt_d = cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset drops any partial byte and returns the lines to idle.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            rx_q    <= RX_RESET;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b1;
            cs_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            rx_q    <= rx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            cs_q    <= cs_d;
        end
    end

    assign bus.rx_data  = rx_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.spi_sck  = sck_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.spi_cs_n = cs_q;

endmodule
